axi_read_controller: RTL

AXI_READ_CONTROLLER -- requirements
Module: axi_read_controller

---
 rtl/axi_sorter_pkg.sv | 22 ++
 rtl/leaf_onehot_decoder.sv | 21 ++
 rtl/axi_read_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/axi_sorter_pkg.sv
// Definitions shared by the merger-tree read and write controllers:
// AXIS width, terminator item, terminator key field and FSM encoding.
package axi_sorter_pkg;

    localparam int AXIS_DATA_W   = 512;
    localparam int TERM_FIELD_HI = 31;
    localparam int TERM_FIELD_LO = 0;
    localparam int TERM_FIELD_W  = TERM_FIELD_HI - TERM_FIELD_LO + 1;

    localparam logic [AXIS_DATA_W-1:0] AXIS_TERMINATOR = {AXIS_DATA_W{1'b0}};

    typedef enum logic [0:0] {
        S_STREAM = 1'b0,
        S_FLUSH  = 1'b1
    } sorter_state_e;

    // A key field equal to the terminator's key marks end-of-set inside the tree.
    function automatic logic is_terminator_field(input logic [TERM_FIELD_W-1:0] field);
        return field == AXIS_TERMINATOR[TERM_FIELD_HI:TERM_FIELD_LO];
    endfunction

endpackage

// File: rtl/leaf_onehot_decoder.sv
// Turns a leaf index plus enable into a one-hot-or-zero write strobe vector.
module leaf_onehot_decoder #(
    parameter int NUM_LEAVES = 32,
    parameter int IDX_W      = 5
) (
    input  logic                  en,
    input  logic [IDX_W-1:0]      idx,
    output logic [NUM_LEAVES-1:0] onehot
);

    // Index decode; an index beyond the leaf count cannot occur by construction.
    always_comb begin
        onehot = {NUM_LEAVES{1'b0}};
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = {NUM_LEAVES{1'b0}};
        end
    end

endmodule

// File: rtl/axi_read_controller.sv
// Distributes an AXIS input set round-robin over the merger-tree leaf FIFOs,
// then flushes one terminator into every leaf before taking the next set.
module axi_read_controller
    import axi_sorter_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = AXIS_DATA_W,
    parameter int C_NUM_LEAVES       = 32
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_areset,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    input  logic [C_NUM_LEAVES-1:0]         leaf_fifo_full,
    output logic [C_NUM_LEAVES-1:0]         leaf_fifo_enq,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   leaf_fifo_item,
    output logic                            stream_done,
    output logic                            protocol_err,
    output logic [31:0]                     beat_cnt
);

    localparam int               IDX_W    = (C_NUM_LEAVES > 1) ? $clog2(C_NUM_LEAVES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_LEAVES - 1);
    localparam logic [C_AXIS_TDATA_WIDTH-1:0] TERM_ITEM = C_AXIS_TDATA_WIDTH'(AXIS_TERMINATOR);

    sorter_state_e                 state_r, state_n_s;
    logic [IDX_W-1:0]              leaf_idx_r, leaf_idx_n_s;
    logic [IDX_W-1:0]              flush_idx_r, flush_idx_n_s;
    logic                          tready_s;
    logic                          accept_s;
    logic                          wr_en_s;
    logic [IDX_W-1:0]              wr_idx_s;
    logic [C_AXIS_TDATA_WIDTH-1:0] wr_data_s;
    logic                          stream_done_n_s;
    logic [C_NUM_LEAVES-1:0]       enq_next_s;
    logic [C_NUM_LEAVES-1:0]       leaf_fifo_enq_r;
    logic [C_AXIS_TDATA_WIDTH-1:0] leaf_fifo_item_r;
    logic                          stream_done_r;
    logic                          protocol_err_r;
    logic [31:0]                   beat_cnt_r;
    logic                          unused_tkeep_s;

    assign unused_tkeep_s = ^s_axis_tkeep;

    // Next-state, handshake and write-scheduling logic.
    always_comb begin
        state_n_s       = state_r;
        leaf_idx_n_s    = leaf_idx_r;
        flush_idx_n_s   = flush_idx_r;
        tready_s        = 1'b0;
        accept_s        = 1'b0;
        wr_en_s         = 1'b0;
        wr_idx_s        = leaf_idx_r;
        wr_data_s       = s_axis_tdata;
        stream_done_n_s = 1'b0;
        case (state_r)
            S_STREAM: begin
                if (s_axis_areset) begin
                    tready_s = 1'b0;
                end else begin
                    tready_s = !leaf_fifo_full[leaf_idx_r];
                end
                accept_s = s_axis_tvalid & tready_s;
                if (accept_s) begin
                    wr_en_s      = 1'b1;
                    leaf_idx_n_s = (leaf_idx_r == LAST_IDX) ? {IDX_W{1'b0}} : leaf_idx_r + IDX_W'(1);
                    if (s_axis_tlast) begin
                        state_n_s     = S_FLUSH;
                        flush_idx_n_s = {IDX_W{1'b0}};
                    end else begin
                        state_n_s = S_STREAM;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            S_FLUSH: begin
                wr_idx_s  = flush_idx_r;
                wr_data_s = TERM_ITEM;
                if (!leaf_fifo_full[flush_idx_r]) begin
                    wr_en_s = 1'b1;
                    if (flush_idx_r == LAST_IDX) begin
                        state_n_s       = S_STREAM;
                        leaf_idx_n_s    = {IDX_W{1'b0}};
                        flush_idx_n_s   = {IDX_W{1'b0}};
                        stream_done_n_s = 1'b1;
                    end else begin
                        flush_idx_n_s = flush_idx_r + IDX_W'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                state_n_s = S_STREAM;
            end
        endcase
    end

    leaf_onehot_decoder #(
        .NUM_LEAVES (C_NUM_LEAVES),
        .IDX_W      (IDX_W)
    ) u_leaf_onehot_decoder (
        .en     (wr_en_s),
        .idx    (wr_idx_s),
        .onehot (enq_next_s)
    );

    // State and registered outputs; the item register holds between writes.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_r          <= S_STREAM;
            leaf_idx_r       <= {IDX_W{1'b0}};
            flush_idx_r      <= {IDX_W{1'b0}};
            leaf_fifo_enq_r  <= {C_NUM_LEAVES{1'b0}};
            leaf_fifo_item_r <= {C_AXIS_TDATA_WIDTH{1'b0}};
            stream_done_r    <= 1'b0;
            protocol_err_r   <= 1'b0;
            beat_cnt_r       <= 32'd0;
        end else begin
            state_r         <= state_n_s;
            leaf_idx_r      <= leaf_idx_n_s;
            flush_idx_r     <= flush_idx_n_s;
            leaf_fifo_enq_r <= enq_next_s;
            stream_done_r   <= stream_done_n_s;
            if (wr_en_s) begin
                leaf_fifo_item_r <= wr_data_s;
            end
            if (accept_s) begin
                beat_cnt_r <= beat_cnt_r + 32'd1;
                if (is_terminator_field(s_axis_tdata[TERM_FIELD_HI:TERM_FIELD_LO])) begin
                    protocol_err_r <= 1'b1;
                end
            end
        end
    end

    assign s_axis_tready  = tready_s;
    assign leaf_fifo_enq  = leaf_fifo_enq_r;
    assign leaf_fifo_item = leaf_fifo_item_r;
    assign stream_done    = stream_done_r;
    assign protocol_err   = protocol_err_r;
    assign beat_cnt       = beat_cnt_r;

endmodule
